// File: rtl/fpu_add_pkg.sv
// fpu_add_pkg: op encodings and segment-count helper shared by the mantissa adder pipeline.
package fpu_add_pkg;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_RSUB = 2'b10;

    function automatic int nseg(input int swr, input int seg_w);
        return (swr + seg_w - 1) / seg_w;
    endfunction
endpackage

// File: rtl/add_seg_pg.sv
// add_seg_pg: combinational W-bit ripple adder returning sum, propagate, per-bit carry-in and carry out.
module add_seg_pg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic [W-1:0] p,
    output logic [W-1:0] c,
    output logic         cout
);
    assign p = a ^ b;

    always_comb begin
        logic cy;
        sum = '0;
        c = '0;
        cy = cin;
        for (int i = 0; i < W; i++) begin
            c[i] = cy;
            sum[i] = p[i] ^ cy;
            cy = (a[i] & b[i]) | (p[i] & cy);
        end
        cout = cy;
    end
endmodule

// File: rtl/add_subt_pipe.sv
// add_subt_pipe: segment-pipelined add/sub/reverse-sub with one carry-chain segment per stage,
// valid tag, global stall and flush; sum, propagate and carries all leave together at the last stage.
module add_subt_pipe
    import fpu_add_pkg::*;
#(
    parameter int SWR   = 26,
    parameter int SEG_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic           flush_i,
    input  logic           valid_i,
    input  logic [1:0]     op_i,
    input  logic [SWR-1:0] Data_A_i,
    input  logic [SWR-1:0] Data_B_i,
    output logic           valid_o,
    output logic [SWR-1:0] Data_Result_o,
    output logic [SWR-1:0] P_o,
    output logic [SWR-1:1] Cn_o,
    output logic           C_o,
    output logic           zero_o
);
    localparam int NSEG = nseg(SWR, SEG_W);

    logic [SWR-1:0] x0, y0;
    logic           cin0;

    assign x0   = (op_i == OP_RSUB) ? Data_B_i : Data_A_i;
    assign y0   = (op_i == OP_SUB) ? ~Data_B_i : (op_i == OP_RSUB) ? ~Data_A_i : Data_B_i;
    assign cin0 = (op_i == OP_SUB) || (op_i == OP_RSUB);

    for (genvar k = 0; k < NSEG; k++) begin : stage
        localparam int LO = k * SEG_W;
        localparam int W  = (SWR - LO < SEG_W) ? SWR - LO : SEG_W;

        logic           v_in;
        logic [SWR-1:0] x_in, y_in, r_in, p_in, r_nx, p_nx;
        logic [SWR:0]   c_in, c_nx;
        logic [W-1:0]   s, pp, cc;
        logic           co;

        if (k == 0) begin : src
            assign v_in = valid_i;
            assign x_in = x0;
            assign y_in = y0;
            assign r_in = '0;
            assign p_in = '0;
            assign c_in = {{SWR{1'b0}}, cin0};
        end else begin : src
            assign v_in = stage[k-1].pipe.v_q;
            assign x_in = stage[k-1].pipe.x_q;
            assign y_in = stage[k-1].pipe.y_q;
            assign r_in = stage[k-1].pipe.r_q;
            assign p_in = stage[k-1].pipe.p_q;
            assign c_in = stage[k-1].pipe.c_q;
        end

        add_seg_pg #(.W(W)) u_seg (
            .a   (x_in[LO+:W]),
            .b   (y_in[LO+:W]),
            .cin (c_in[LO]),
            .sum (s),
            .p   (pp),
            .c   (cc),
            .cout(co)
        );

        // c vectors index the carry into each bit; bit SWR is the final carry out
        always_comb begin
            r_nx = r_in;
            r_nx[LO+:W] = s;
            p_nx = p_in;
            p_nx[LO+:W] = pp;
            c_nx = c_in;
            c_nx[LO+:W+1] = {co, cc};
        end

        if (k < NSEG - 1) begin : pipe
            logic           v_q;
            logic [SWR-1:0] x_q, y_q, r_q, p_q;
            logic [SWR:0]   c_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_q <= 1'b0;
                    x_q <= '0;
                    y_q <= '0;
                    r_q <= '0;
                    p_q <= '0;
                    c_q <= '0;
                end else begin
                    v_q <= flush_i ? 1'b0 : en_i ? v_in : v_q;
                    if (en_i) begin
                        x_q <= x_in;
                        y_q <= y_in;
                        r_q <= r_nx;
                        p_q <= p_nx;
                        c_q <= c_nx;
                    end
                end
            end
        end else begin : last
            // bubbles and flushed ops leave the last valid result in place
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_o       <= 1'b0;
                    Data_Result_o <= '0;
                    P_o           <= '0;
                    Cn_o          <= '0;
                    C_o           <= 1'b0;
                    zero_o        <= 1'b1;
                end else begin
                    valid_o <= flush_i ? 1'b0 : en_i ? v_in : valid_o;
                    if (en_i && v_in && !flush_i) begin
                        Data_Result_o <= r_nx;
                        P_o           <= p_nx;
                        Cn_o          <= c_nx[SWR-1:1];
                        C_o           <= c_nx[SWR];
                        zero_o        <= ~|r_nx;
                    end
                end
            end
        end
    end
endmodule
